// File: rtl/ift_tag_trace_recorder_if.sv
// Record read-out bus of the tag trace recorder: valid/ready handshake on the
// FIFO head, plus occupancy and the sticky drop flag.
interface ift_tag_trace_recorder_if #(
    parameter int DATA_W = 1,
    parameter int TAG_W  = 32,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16
);
    logic                            rec_valid;
    logic                            rec_ready;
    logic [TAG_W+DATA_W+TS_W-1:0]    rec_data;
    logic [$clog2(DEPTH):0]          rec_count;
    logic                            overflow;

    // Recorder side drives records out.
    modport master (
        output rec_valid, rec_data, rec_count, overflow,
        input  rec_ready
    );

    // Consumer side (bench or dump engine).
    modport slave (
        input  rec_valid, rec_data, rec_count, overflow,
        output rec_ready
    );
endinterface

// File: rtl/ift_tag_trace_recorder.sv
// Tag trace recorder: samples {tag_i, sig_i} each enabled cycle and pushes a
// {tag, data, time} record into a show-ahead FIFO whenever the pair changes
// (or on the first enabled cycle after arming).
// Build option IFT_REC_ABS_TIME_EN: time field is the absolute enabled-cycle
// count since reset instead of the delta since the previous record.
module ift_tag_trace_recorder #(
    parameter int DATA_W = 1,
    parameter int TAG_W  = 32,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_W-1:0]        sig_i,
    input  logic [TAG_W-1:0]         tag_i,
    ift_tag_trace_recorder_if.master rec
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int VAL_W = TAG_W + DATA_W;
    localparam int REC_W = VAL_W + TS_W;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             armed;
    logic             ovf;
    logic [TS_W-1:0]  time_cnt;
    logic [VAL_W-1:0] last_val;

    logic [VAL_W-1:0] cur;
    logic [TS_W-1:0]  rec_time;
    logic [TS_W-1:0]  time_inc;
    logic             evt, full, pop, push;

    // Event detection and FIFO handshake decode.
    always_comb begin
        cur      = {tag_i, sig_i};
        evt      = en && (!armed || (cur != last_val));
        full     = (count == CW'(DEPTH));
        pop      = (count != '0) && rec.rec_ready;
        push     = evt && (!full || pop);
        time_inc = (time_cnt == {TS_W{1'b1}}) ? time_cnt : time_cnt + 1'b1;
`ifdef IFT_REC_ABS_TIME_EN
        rec_time = time_cnt;
`else
        // First record after (re)arming always carries time 0.
        rec_time = armed ? time_cnt : '0;
`endif
    end

    // Sampling state: arm flag, last observed value, time counter, drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            last_val <= '0;
            time_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (en) begin
                armed <= 1'b1;
`ifdef IFT_REC_ABS_TIME_EN
                time_cnt <= time_inc;
`else
                time_cnt <= evt ? TS_W'(1) : time_inc;
`endif
                // Last value tracks events even when the record is dropped.
                if (evt) last_val <= cur;
            end else begin
                armed <= 1'b0;
            end
            if (evt && full && !pop) ovf <= 1'b1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents are only visible through rec_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cur, rec_time};
    end

    assign rec.rec_valid = (count != '0);
    assign rec.rec_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign rec.rec_count = count;
    assign rec.overflow  = ovf;

endmodule

// File: tb/tb_ift_tag_trace_recorder.sv
// Self-checking bench for ift_tag_trace_recorder (DEPTH=4 build). A queue
// based reference model computes expected records from enabled-cycle indices.
module tb_ift_tag_trace_recorder;
    localparam int DATA_W = 1;
    localparam int TAG_W  = 32;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 4;
    localparam int REC_W  = TAG_W + DATA_W + TS_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DATA_W-1:0] sig = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic              ready = 1'b0;

    int checks = 0;
    int failures = 0;

    ift_tag_trace_recorder_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TS_W(TS_W), .DEPTH(DEPTH)) rif ();
    assign rif.rec_ready = ready;

    ift_tag_trace_recorder #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sig_i (sig),
        .tag_i (tag),
        .rec   (rif.master)
    );

    always #5 clk = ~clk;

    // Reference model: records hold the number of enabled cycles since the
    // previous record (or 0 right after arming), or the absolute enabled count.
    logic [REC_W-1:0]        q[$];
    bit                      m_armed;
    logic [TAG_W+DATA_W-1:0] m_last;
    longint                  m_ecyc, m_lastev;
    bit                      m_ovf;

    task automatic m_reset();
        q.delete();
        m_armed = 0; m_last = '0; m_ecyc = 0; m_lastev = 0; m_ovf = 0;
    endtask

    function automatic logic [REC_W-1:0] exp_head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    // Advance one clock: update the model with current inputs, then let the
    // DUT see the edge and settle.
    task automatic step();
        logic [TAG_W+DATA_W-1:0] cur;
        logic [TS_W-1:0]         t;
        bit                      pp, ev;
        cur = {tag, sig};
        pp  = (q.size() != 0) && ready;
        if (pp) void'(q.pop_front());
        if (en) begin
            ev = !m_armed || (cur != m_last);
`ifdef IFT_REC_ABS_TIME_EN
            t = TS_W'(m_ecyc);
`else
            t = m_armed ? TS_W'(m_ecyc - m_lastev) : '0;
`endif
            if (ev) begin
                if (q.size() < DEPTH) q.push_back({cur, t});
                else m_ovf = 1;
                m_last = cur;
                m_lastev = m_ecyc;
            end
            m_armed = 1;
            m_ecyc++;
        end else begin
            m_armed = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; en = 1'b0; sig = '0; tag = '0; ready = 1'b0;
        #3;
        m_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (rif.rec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rif.rec_valid); end
        checks++; if (rif.rec_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rif.rec_data); end
        checks++; if (rif.rec_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rif.rec_count); end
        checks++; if (rif.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", rif.overflow); end
        do_reset();
    endtask

    task automatic test_single_record();
        logic [REC_W-1:0] e;
        do_reset();
        en = 1'b1; sig = '0; tag = '0; ready = 1'b0;
        repeat (5) step();
        e = '0;
        checks++; if (rif.rec_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", rif.rec_count); end
        checks++; if (rif.rec_data !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", rif.rec_data, e); end
        checks++; if (rif.rec_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rif.rec_valid); end
    endtask

    task automatic test_tag_change();
        logic [REC_W-1:0] e;
        do_reset();
        en = 1'b1; ready = 1'b1;
        repeat (3) step();
        tag = 32'h0000_0004;
        step();
        e = {32'h4, 1'b0, 32'd3};
        checks++; if (rif.rec_data !== e) begin failures++; $display("FAIL tagchg_data got=%h exp=%h", rif.rec_data, e); end
        checks++; if (rif.rec_count !== 3'd1) begin failures++; $display("FAIL tagchg_count got=%0d exp=1", rif.rec_count); end
    endtask

    task automatic test_overflow();
        logic [REC_W-1:0] e;
        do_reset();
        en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sig = 1'(i);
            step();
        end
        checks++; if (rif.rec_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", rif.rec_count); end
        checks++; if (rif.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", rif.overflow); end
        en = 1'b0; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef IFT_REC_ABS_TIME_EN
            e = {32'h0, 1'(i), 32'(i)};
`else
            e = {32'h0, 1'(i), (i == 0) ? 32'd0 : 32'd1};
`endif
            checks++; if (rif.rec_data !== e) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rif.rec_data, e); end
            step();
        end
        checks++; if (rif.rec_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", rif.rec_valid); end
        checks++; if (rif.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", rif.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [REC_W-1:0] e;
        do_reset();
        en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig = 1'(i);
            step();
        end
        sig = 1'b0; ready = 1'b1;
        step();
        checks++; if (rif.rec_count !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", rif.rec_count); end
        checks++; if (rif.overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%b exp=0", rif.overflow); end
        en = 1'b0;
        repeat (3) step();
`ifdef IFT_REC_ABS_TIME_EN
        e = {32'h0, 1'b0, 32'd4};
`else
        e = {32'h0, 1'b0, 32'd1};
`endif
        checks++; if (rif.rec_data !== e) begin failures++; $display("FAIL fpp_tail got=%h exp=%h", rif.rec_data, e); end
    endtask

    task automatic test_rearm();
        logic [REC_W-1:0] e;
        do_reset();
        en = 1'b1; sig = 1'b1; tag = 32'h7; ready = 1'b0;
        repeat (3) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        step();
        checks++; if (rif.rec_count !== 3'd2) begin failures++; $display("FAIL rearm_count got=%0d exp=2", rif.rec_count); end
        ready = 1'b1; en = 1'b0;
        step();
`ifdef IFT_REC_ABS_TIME_EN
        e = {32'h7, 1'b1, 32'd3};
`else
        e = {32'h7, 1'b1, 32'd0};
`endif
        checks++; if (rif.rec_data !== e) begin failures++; $display("FAIL rearm_data got=%h exp=%h", rif.rec_data, e); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sig = 1'(i);
            step();
        end
        ready = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rif.rec_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", rif.rec_valid); end
        checks++; if (rif.rec_count !== '0) begin failures++; $display("FAIL arst_count got=%0d exp=0", rif.rec_count); end
        checks++; if (rif.overflow !== 1'b0) begin failures++; $display("FAIL arst_overflow got=%b exp=0", rif.overflow); end
        m_reset();
        en = 1'b0; ready = 1'b0;
        #1 rst_n = 1'b1;
        en = 1'b1; sig = 1'b1;
        step();
        checks++; if (rif.rec_data !== {32'h0, 1'b1, 32'd0}) begin failures++; $display("FAIL arst_fresh got=%h exp=%h", rif.rec_data, {32'h0, 1'b1, 32'd0}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            sig   = 1'($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0: tag = 32'h0;
                1: tag = 32'h4;
                2: tag = 32'hdead_beef;
                default: tag = tag;
            endcase
            step();
            checks++;
            if (rif.rec_valid !== (q.size() != 0) || rif.rec_data !== exp_head() ||
                rif.rec_count !== 3'(q.size()) || rif.overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand_cyc%0d got v=%b d=%h c=%0d o=%b exp v=%b d=%h c=%0d o=%b", i,
                         rif.rec_valid, rif.rec_data, rif.rec_count, rif.overflow,
                         (q.size() != 0), exp_head(), q.size(), m_ovf);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single_record();
        test_tag_change();
        test_overflow();
        test_full_push_pop();
        test_rearm();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
